// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencing controller.
// Holds the key code map, FSM state encodings, operator encoding and
// default operand/result sizing. No ports; imported by calc_ctrl and
// calc_mul_seq.
package calc_pkg;

  localparam int DEF_MAX_DIGITS = 4;
  localparam int DEF_OPB_W      = 14;
  localparam int DEF_RES_W      = 28;
  localparam int DEF_RES_MAX    = 99_999_999;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_EQ  = 4'hD;
  localparam logic [3:0] KEY_CLR = 4'hE;
  localparam logic [3:0] KEY_BSP = 4'hF;

  localparam logic [2:0] ST_ENTER_A = 3'd0;
  localparam logic [2:0] ST_ENTER_B = 3'd1;
  localparam logic [2:0] ST_CALC    = 3'd2;
  localparam logic [2:0] ST_CHECK   = 3'd3;
  localparam logic [2:0] ST_SHOW    = 3'd4;
  localparam logic [2:0] ST_ERR     = 3'd5;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2,
    OP_MUL  = 2'd3
  } op_e;

  function automatic op_e key_to_op(input logic [3:0] key);
    op_e op;
    case (key)
      KEY_ADD: op = OP_ADD;
      KEY_SUB: op = OP_SUB;
      KEY_MUL: op = OP_MUL;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/calc_mul_seq.sv
// Sequential unsigned shift-add multiplier.
// Ports:
//   clk, rst_n  system clock, async active-low reset
//   i_start     load operands and begin; ignored while running
//   i_abort     synchronous abort, returns to idle
//   i_a, i_b    unsigned multiplicand / multiplier
//   o_done      high during the final iteration; o_prod is final next cycle
//   o_prod      product accumulator
// One multiplier bit is consumed per cycle, LSB first, B_W cycles total.
module calc_mul_seq
  import calc_pkg::*;
#(
  parameter int A_W = DEF_RES_W,
  parameter int B_W = DEF_OPB_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [A_W-1:0]     i_a,
  input  logic [B_W-1:0]     i_b,
  output logic               o_done,
  output logic [A_W+B_W-1:0] o_prod
);

  localparam int P_W   = A_W + B_W;
  localparam int CNT_W = $clog2(B_W);

  logic             r_run;
  logic [CNT_W-1:0] r_cnt;
  logic [P_W-1:0]   r_mcand;
  logic [B_W-1:0]   r_mplier;
  logic [P_W-1:0]   r_acc;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(B_W - 1));
  assign o_done = r_run & w_last;
  assign o_prod = r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run    <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_abort) begin
      r_run <= 1'b0;
      r_cnt <= '0;
    end else if (!r_run) begin
      if (i_start) begin
        r_run    <= 1'b1;
        r_cnt    <= '0;
        r_mcand  <= {{B_W{1'b0}}, i_a};
        r_mplier <= i_b;
        r_acc    <= '0;
      end
    end else begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= {r_mcand[P_W-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[B_W-1:1]};
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_ctrl.sv
// Calculator sequencing controller: operand entry, operator latch,
// add/sub, sequential multiply, range check and result hold.
// Ports:
//   clk, rst_n  system clock, async active-low reset
//   key_valid   one-cycle strobe qualifying key_code
//   key_code    0-9 digit, A + , B - , C * , D = , E clear, F backspace
//   disp_val    signed value for the digit display
//   busy        arithmetic in progress (CALC/CHECK)
//   err         sticky out-of-range flag, cleared by clear key
//   op_pending  latched operator (0 none, 1 add, 2 sub, 3 mul)
//
// state    | meaning
// ENTER_A  | collecting first operand digits
// ENTER_B  | operator latched, collecting second operand digits
// CALC     | add/sub for one cycle, or waiting on the multiplier
// CHECK    | range check of the full-width result
// SHOW     | result held on display, A = result
// ERR      | result out of range, only clear is accepted
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = DEF_MAX_DIGITS,
  parameter int OPB_W      = DEF_OPB_W,
  parameter int RES_W      = DEF_RES_W,
  parameter int RES_MAX    = DEF_RES_MAX
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_valid,
  input  logic [3:0]              key_code,
  output logic signed [RES_W-1:0] disp_val,
  output logic                    busy,
  output logic                    err,
  output logic [1:0]              op_pending
);

  localparam int ACC_W = RES_W + OPB_W;
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [ACC_W-1:0] LP_RES_MAX = ACC_W'(RES_MAX);

  logic [2:0]       r_state;
  logic [OPB_W-1:0] r_entry;
  logic [CNT_W-1:0] r_cnt;
  logic [RES_W-1:0] r_a;
  logic [OPB_W-1:0] r_b;
  op_e              r_op;
  logic             r_chain;
  op_e              r_chain_op;
  logic [ACC_W-1:0] r_acc;
  logic [RES_W-1:0] r_disp;
  logic             r_err;

  logic             w_is_digit, w_is_op, w_is_eq, w_is_clr, w_is_bsp;
  op_e              w_key_op;
  logic             w_clr;
  logic             w_calc_go;
  logic             w_mul_start;
  logic             w_mul_done;
  logic [ACC_W-1:0] w_prod;
  logic [RES_W-1:0] w_a_mag;
  logic [OPB_W-1:0] w_b_opnd;
  logic [OPB_W-1:0] w_entry_dig;
  logic [OPB_W-1:0] w_entry_bsp;
  logic [ACC_W-1:0] w_a_ext, w_b_ext;
  logic [ACC_W-1:0] w_mag;
  logic             w_neg;
  logic             w_ovf;
  logic [RES_W-1:0] w_res;

  assign w_is_digit = (key_code <= 4'd9);
  assign w_is_op    = (key_code == KEY_ADD) || (key_code == KEY_SUB) || (key_code == KEY_MUL);
  assign w_is_eq    = (key_code == KEY_EQ);
  assign w_is_clr   = (key_code == KEY_CLR);
  assign w_is_bsp   = (key_code == KEY_BSP);
  assign w_key_op   = key_to_op(key_code);
  assign w_clr      = key_valid && w_is_clr;

  // A chained operator in ENTER_B with digits behaves as '=' first.
  assign w_calc_go = key_valid &&
                     (((r_state == ST_ENTER_B) && (w_is_eq || (w_is_op && (r_cnt != '0)))) ||
                      ((r_state == ST_SHOW) && w_is_eq));
  assign w_mul_start = w_calc_go && (r_op == OP_MUL);

  // In SHOW, '=' repeats with the last B; otherwise B is the fresh entry.
  assign w_b_opnd = (r_state == ST_SHOW) ? r_b : r_entry;
  assign w_a_mag  = r_a[RES_W-1] ? (-r_a) : r_a;

  assign w_entry_dig = (r_entry * OPB_W'(10)) + OPB_W'(key_code);
  assign w_entry_bsp = r_entry / OPB_W'(10);

  assign w_a_ext = {{OPB_W{r_a[RES_W-1]}}, r_a};
  assign w_b_ext = {{RES_W{1'b0}}, r_b};

  calc_mul_seq #(
    .A_W (RES_W),
    .B_W (OPB_W)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_mul_start),
    .i_abort (w_clr),
    .i_a     (w_a_mag),
    .i_b     (w_b_opnd),
    .o_done  (w_mul_done),
    .o_prod  (w_prod)
  );

  // Multiply runs on |A|; the sign of A is reapplied after the range check.
  always_comb begin
    w_neg = 1'b0;
    w_mag = '0;
    if (r_op == OP_MUL) begin
      w_neg = r_a[RES_W-1];
      w_mag = w_prod;
    end else begin
      w_neg = r_acc[ACC_W-1];
      w_mag = w_neg ? (-r_acc) : r_acc;
    end
  end

  assign w_ovf = (w_mag > LP_RES_MAX);
  assign w_res = w_neg ? (-w_mag[RES_W-1:0]) : w_mag[RES_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_ENTER_A;
      r_entry    <= '0;
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= OP_NONE;
      r_chain    <= 1'b0;
      r_chain_op <= OP_NONE;
      r_acc      <= '0;
      r_disp     <= '0;
      r_err      <= 1'b0;
    end else if (w_clr) begin
      r_state    <= ST_ENTER_A;
      r_entry    <= '0;
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= OP_NONE;
      r_chain    <= 1'b0;
      r_chain_op <= OP_NONE;
      r_acc      <= '0;
      r_disp     <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_ENTER_A, ST_ENTER_B: begin
          if (key_valid) begin
            if (w_is_digit) begin
              if (r_cnt != CNT_W'(MAX_DIGITS)) begin
                r_entry <= w_entry_dig;
                r_disp  <= RES_W'(w_entry_dig);
                // leading zeros do not consume a digit position
                if ((r_entry != '0) || (key_code != 4'd0)) r_cnt <= r_cnt + CNT_W'(1);
              end
            end else if (w_is_bsp) begin
              r_entry <= w_entry_bsp;
              r_disp  <= RES_W'(w_entry_bsp);
              if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
            end else if (w_is_op) begin
              if (r_state == ST_ENTER_A) begin
                r_a     <= RES_W'(r_entry);
                r_disp  <= RES_W'(r_entry);
                r_op    <= w_key_op;
                r_entry <= '0;
                r_cnt   <= '0;
                r_state <= ST_ENTER_B;
              end else if (r_cnt == '0) begin
                r_op <= w_key_op;
              end else begin
                r_b        <= r_entry;
                r_chain    <= 1'b1;
                r_chain_op <= w_key_op;
                r_entry    <= '0;
                r_cnt      <= '0;
                r_state    <= ST_CALC;
              end
            end else if (w_is_eq && (r_state == ST_ENTER_B)) begin
              r_b     <= r_entry;
              r_chain <= 1'b0;
              r_entry <= '0;
              r_cnt   <= '0;
              r_state <= ST_CALC;
            end
          end
        end
        ST_SHOW: begin
          if (key_valid) begin
            if (w_is_digit) begin
              r_entry <= OPB_W'(key_code);
              r_cnt   <= (key_code != 4'd0) ? CNT_W'(1) : '0;
              r_disp  <= RES_W'(key_code);
              r_op    <= OP_NONE;
              r_state <= ST_ENTER_A;
            end else if (w_is_op) begin
              r_op    <= w_key_op;
              r_state <= ST_ENTER_B;
            end else if (w_is_eq) begin
              r_chain <= 1'b0;
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (r_op == OP_MUL) begin
            if (w_mul_done) r_state <= ST_CHECK;
          end else begin
            r_acc   <= (r_op == OP_SUB) ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_ovf) begin
            r_err   <= 1'b1;
            r_disp  <= '0;
            r_state <= ST_ERR;
          end else begin
            r_disp <= w_res;
            r_a    <= w_res;
            if (r_chain) begin
              r_op    <= r_chain_op;
              r_chain <= 1'b0;
              r_state <= ST_ENTER_B;
            end else begin
              r_state <= ST_SHOW;
            end
          end
        end
        ST_ERR: begin
        end
        default: r_state <= ST_ENTER_A;
      endcase
    end
  end

  assign disp_val   = r_disp;
  assign busy       = (r_state == ST_CALC) || (r_state == ST_CHECK);
  assign err        = r_err;
  assign op_pending = r_op;

endmodule

// File: doc/calc_ctrl.md
Name: calc_ctrl

Overview:
Calculator sequencing controller that consumes decoded key events from the keypad scanner and drives operand entry, operator latch, arithmetic and result hold. Owns a small add/sub unit and a sequential shift-add multiplier sub-module, and presents one signed display value to the display driver. Sits between the keypad scan/decode block and the digit display block.

Parameters:
MAX_DIGITS, 4, max decimal digits per entered operand
OPB_W, 14, binary width of an entered operand (holds 9999)
RES_W, 28, signed width of accumulator/result/display value
RES_MAX, 99_999_999, largest legal result magnitude (8 display digits)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
key_valid  in  1  one-cycle pulse, key_code valid
key_code  in  4  0-9 digit, A '+', B '-', C '*', D '=', E clear, F backspace
disp_val  out  RES_W  signed value to display
busy  out  1  arithmetic in progress, keys other than clear ignored
err  out  1  result out of range, sticky until clear
op_pending  out  2  latched operator: 0 none, 1 add, 2 sub, 3 mul

Behaviour:
- Reset (async, rst_n low): state ENTER_A, A=B=0, digit count 0, disp_val=0, busy=0, err=0, op_pending=0.
- States: ENTER_A, ENTER_B, CALC, CHECK, SHOW, ERR.
- Digit in ENTER_A/ENTER_B: value=value*10+d, count+1; ignored when count==MAX_DIGITS; digit 0 with value 0 leaves count 0. disp_val follows entered value next cycle.
- Backspace in entry states: value=value/10, count-1 (saturate at 0); elsewhere ignored.
- Operator in ENTER_A: latch op, A=entry (0 if no digits), go ENTER_B, disp_val=A.
- Operator in ENTER_B with no B digits: replace op only. With digits: treat as '=' then latch the new op on entering ENTER_B with A=result (chained).
- Operator in SHOW: A=result, latch op, go ENTER_B.
- '=' in ENTER_A: no-op. '=' in ENTER_B: B=entry (0 if none), go CALC. '=' in SHOW: repeat last op with last B, A=result.
- Digit in SHOW: start new A (count 1), go ENTER_A, op cleared.
- Timing, key accepted cycle t: CALC starts t+1. Add/sub: CALC 1 cycle, CHECK t+2, disp_val/err valid t+3. Mul: CALC t+1..t+14 (one B bit per cycle, LSB first, on |A|, sign reapplied), CHECK t+15, valid t+16. busy high from t+1 through CHECK.
- Arithmetic: A signed RES_W, B unsigned OPB_W; mul accumulator RES_W+OPB_W bits; CHECK compares full-width magnitude against RES_MAX.
- Out of range: err=1, disp_val=0, state ERR; all keys except clear ignored.
- Clear (E): any state including CALC/ERR, next cycle → ENTER_A, everything at reset values; aborts multiplier.
- key_valid while busy (non-clear): dropped, no queueing.
- Division not supported; key codes fully decoded, no illegal codes.

Decomposition:
- calc_pkg: key code constants, state enum, op encoding, OPB_W/RES_W/RES_MAX defaults.
- Sub-module calc_mul_seq: start/done handshake, unsigned shift-add, OPB_W iterations, start ignored while running, sync abort input.

Test Plan:
- Keys 1,2,+,3,4,= → disp_val 46 at t+3 after '=', busy high for exactly 2 cycles, err 0.
- Keys 2,5,-,1,0,0,= → disp_val -75; then '=' again → -175.
- Keys 9,9,9,9,*,9,9,9,9,= → busy 15 cycles, disp_val 99_980_001 at t+16; then *,2,= → err=1, disp_val 0; digit keys ignored; E → disp_val 0, err 0.
- Keys 1,2,3,4,5 → disp_val 1234 (5th digit dropped); F → 123; F,F,F,F → 0 with no underflow.
- Keys 7,+,-,3,= → op replaced, disp_val 4; keys 5,+,3,* → disp_val 8, op_pending 3.
- Start 9*9=; pulse rst_n low at t+5 → all outputs 0 immediately; afterwards 1,+,1,= → 2. Key 3 pulsed while busy → dropped.
